// File: rtl/icetap_spi_scan_bridge.sv
// SPI slave (mode 0, LSB first) that feeds the icetap_scan register strobes.
//
// All SPI pins are oversampled in the scan_clk domain, so no logic runs on SCLK.
// Each frame starts with an 8-bit address. The address selects one scan register,
// and every payload bit after it becomes a one-cycle shift strobe for that register.
//
// Ports
//   scan_clk                 in   sole clock, must run at least 8x spi_sclk
//   scan_reset_              in   asynchronous active-low reset
//   spi_sclk/spi_cs_/spi_mosi in  asynchronous SPI pins (SCLK idles low, CS_ active low)
//   spi_miso                 out  registered serial data from the selected register
//   spi_miso_oe              out  pad enable, high while CS_ is (synchronised) low
//   cmd_shift_ena/_update/_data             CMD register strobes and payload bit
//   status_shift_update/_ena, status_shift_data (in)  STATUS capture/shift, serial out
//   store_mask_shift_ena/_data              STORE_MASK strobe and payload bit
//   trigger_mask_shift_ena/_data            TRIGGER_MASK strobe and payload bit
//   data_shift_update/_ena, data_shift_data (in)      DATA readout start/shift, serial out
module icetap_spi_scan_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic scan_clk,
  input  logic scan_reset_,
  input  logic spi_sclk,
  input  logic spi_cs_,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic cmd_shift_ena,
  output logic cmd_shift_update,
  output logic cmd_shift_data,
  output logic status_shift_update,
  output logic status_shift_ena,
  input  logic status_shift_data,
  output logic store_mask_shift_ena,
  output logic store_mask_shift_data,
  output logic trigger_mask_shift_ena,
  output logic trigger_mask_shift_data,
  output logic data_shift_update,
  output logic data_shift_ena,
  input  logic data_shift_data
);

  typedef enum logic [1:0] {StIdle, StAddr, StPayload} state_e;

  typedef enum logic [2:0] {
    SelNone,
    SelCmd,
    SelStatus,
    SelStoreMask,
    SelTriggerMask,
    SelData
  } sel_e;

  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

  function automatic sel_e decode_addr(input logic [7:0] a);
    sel_e s;
    case (a)
      8'h01:   s = SelCmd;
      8'h02:   s = SelStatus;
      8'h03:   s = SelStoreMask;
      8'h04:   s = SelTriggerMask;
      8'h05:   s = SelData;
      default: s = SelNone;
    endcase
    return s;
  endfunction

  // Pin synchronisers. CS_ resets high so that leaving reset never looks like a frame start.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  logic sclk_s, cs_s, mosi_s;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edge detection against the previous synchronised sample.
  logic sclk_d_q, cs_d_q;

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      sclk_d_q <= 1'b0;
      cs_d_q   <= 1'b1;
    end else begin
      sclk_d_q <= sclk_s;
      cs_d_q   <= cs_s;
    end
  end

  logic rise, cs_fall, cs_rise;
  assign rise    = sclk_s & ~sclk_d_q;
  assign cs_fall = ~cs_s & cs_d_q;
  assign cs_rise = cs_s & ~cs_d_q;

  // Frame state
  state_e              state_q, state_d;
  sel_e                sel_q, sel_d;
  logic [7:0]          addr_q, addr_d;
  logic [2:0]          addr_cnt_q, addr_cnt_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;

  // Registered outputs
  logic cmd_ena_q, cmd_ena_d;
  logic status_ena_q, status_ena_d;
  logic store_ena_q, store_ena_d;
  logic trig_ena_q, trig_ena_d;
  logic data_ena_q, data_ena_d;
  logic cmd_upd_q, cmd_upd_d;
  logic status_upd_q, status_upd_d;
  logic data_upd_q, data_upd_d;
  logic shift_data_q, shift_data_d;
  logic miso_q, miso_d;

  logic [7:0] next_addr;
  sel_e       next_sel;
  assign next_addr = {mosi_s, addr_q[7:1]};
  assign next_sel  = decode_addr(next_addr);

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      state_q      <= StIdle;
      sel_q        <= SelNone;
      addr_q       <= '0;
      addr_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      cmd_ena_q    <= 1'b0;
      status_ena_q <= 1'b0;
      store_ena_q  <= 1'b0;
      trig_ena_q   <= 1'b0;
      data_ena_q   <= 1'b0;
      cmd_upd_q    <= 1'b0;
      status_upd_q <= 1'b0;
      data_upd_q   <= 1'b0;
      shift_data_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      addr_cnt_q   <= addr_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_ena_q    <= cmd_ena_d;
      status_ena_q <= status_ena_d;
      store_ena_q  <= store_ena_d;
      trig_ena_q   <= trig_ena_d;
      data_ena_q   <= data_ena_d;
      cmd_upd_q    <= cmd_upd_d;
      status_upd_q <= status_upd_d;
      data_upd_q   <= data_upd_d;
      shift_data_q <= shift_data_d;
      miso_q       <= miso_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    addr_cnt_d   = addr_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    cmd_ena_d    = 1'b0;
    status_ena_d = 1'b0;
    store_ena_d  = 1'b0;
    trig_ena_d   = 1'b0;
    data_ena_d   = 1'b0;
    cmd_upd_d    = 1'b0;
    status_upd_d = 1'b0;
    data_upd_d   = 1'b0;
    shift_data_d = shift_data_q;

    // MISO follows the selected register every cycle.
    case (sel_q)
      SelStatus: miso_d = status_shift_data;
      SelData:   miso_d = data_shift_data;
      default:   miso_d = 1'b0;
    endcase

    // Priority: end of frame, then start of frame, then SCLK rise.
    // A rise that coincides with cs_rise is therefore dropped.
    if (cs_rise) begin
      if (state_q == StPayload && sel_q == SelCmd && bit_cnt_q != '0) begin
        cmd_upd_d = 1'b1;
      end
      state_d = StIdle;
      sel_d   = SelNone;
    end else if (cs_fall) begin
      // Also covers a missed CS_ rise: restart the address phase from scratch.
      state_d    = StAddr;
      sel_d      = SelNone;
      addr_d     = '0;
      addr_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (rise) begin
      case (state_q)
        StAddr: begin
          addr_d     = next_addr;
          addr_cnt_d = addr_cnt_q + 3'd1;
          if (addr_cnt_q == 3'd7) begin
            state_d      = StPayload;
            sel_d        = next_sel;
            status_upd_d = (next_sel == SelStatus);
            data_upd_d   = (next_sel == SelData);
          end
        end
        StPayload: begin
          shift_data_d = mosi_s;
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CntOne;
          end
          case (sel_q)
            SelCmd:         cmd_ena_d    = 1'b1;
            SelStatus:      status_ena_d = 1'b1;
            SelStoreMask:   store_ena_d  = 1'b1;
            SelTriggerMask: trig_ena_d   = 1'b1;
            SelData:        data_ena_d   = 1'b1;
            default:        ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign spi_miso                = miso_q;
  assign spi_miso_oe             = ~cs_s;
  assign cmd_shift_ena           = cmd_ena_q;
  assign cmd_shift_update        = cmd_upd_q;
  assign cmd_shift_data          = shift_data_q;
  assign status_shift_update     = status_upd_q;
  assign status_shift_ena        = status_ena_q;
  assign store_mask_shift_ena    = store_ena_q;
  assign store_mask_shift_data   = shift_data_q;
  assign trigger_mask_shift_ena  = trig_ena_q;
  assign trigger_mask_shift_data = shift_data_q;
  assign data_shift_update       = data_upd_q;
  assign data_shift_ena          = data_ena_q;

endmodule

// File: tb/tb_icetap_spi_scan_bridge.sv
// Self-checking bench for icetap_spi_scan_bridge. Each frame is compared against a
// frame-level model: the ordered list of strobe/update events, the payload bits seen on
// the shift data outputs, and the MISO bits the master samples.
module tb_icetap_spi_scan_bridge;

  localparam int HALF = 6;  // scan_clk cycles per SCLK half period

  logic scan_clk    = 1'b0;
  logic scan_reset_ = 1'b1;
  logic spi_sclk    = 1'b0;
  logic spi_cs_     = 1'b1;
  logic spi_mosi    = 1'b0;
  logic spi_miso, spi_miso_oe;
  logic cmd_shift_ena, cmd_shift_update, cmd_shift_data;
  logic status_shift_update, status_shift_ena, status_shift_data;
  logic store_mask_shift_ena, store_mask_shift_data;
  logic trigger_mask_shift_ena, trigger_mask_shift_data;
  logic data_shift_update, data_shift_ena, data_shift_data;

  int errors = 0;
  int checks = 0;

  icetap_spi_scan_bridge #(
    .SYNC_STAGES(2),
    .CNT_BITS   (16)
  ) dut (
    .scan_clk               (scan_clk),
    .scan_reset_            (scan_reset_),
    .spi_sclk               (spi_sclk),
    .spi_cs_                (spi_cs_),
    .spi_mosi               (spi_mosi),
    .spi_miso               (spi_miso),
    .spi_miso_oe            (spi_miso_oe),
    .cmd_shift_ena          (cmd_shift_ena),
    .cmd_shift_update       (cmd_shift_update),
    .cmd_shift_data         (cmd_shift_data),
    .status_shift_update    (status_shift_update),
    .status_shift_ena       (status_shift_ena),
    .status_shift_data      (status_shift_data),
    .store_mask_shift_ena   (store_mask_shift_ena),
    .store_mask_shift_data  (store_mask_shift_data),
    .trigger_mask_shift_ena (trigger_mask_shift_ena),
    .trigger_mask_shift_data(trigger_mask_shift_data),
    .data_shift_update      (data_shift_update),
    .data_shift_ena         (data_shift_ena),
    .data_shift_data        (data_shift_data)
  );

  always #5 scan_clk = ~scan_clk;

  // Behavioural STATUS and DATA registers downstream of the bridge.
  logic [63:0] status_sr = '0;
  logic [31:0] data_sr   = '0;
  logic [31:0] data_load = '0;

  always @(posedge scan_clk) begin
    if (status_shift_update) status_sr <= {8{8'hA5}};
    else if (status_shift_ena) status_sr <= status_sr >> 1;
    if (data_shift_update) data_sr <= data_load;
    else if (data_shift_ena) data_sr <= data_sr >> 1;
  end

  assign status_shift_data = status_sr[0];
  assign data_shift_data   = data_sr[0];

  // Event log: codes 0..4 = cmd/status/store/trigger/data ena, 5/6/7 = cmd/status/data update.
  logic [4:0]  enas;
  logic [12:0] all_outs;
  assign enas = {data_shift_ena, trigger_mask_shift_ena, store_mask_shift_ena,
                 status_shift_ena, cmd_shift_ena};
  assign all_outs = {spi_miso, spi_miso_oe, cmd_shift_ena, cmd_shift_update, cmd_shift_data,
                     status_shift_update, status_shift_ena, store_mask_shift_ena,
                     store_mask_shift_data, trigger_mask_shift_ena, trigger_mask_shift_data,
                     data_shift_update, data_shift_ena};

  int   ev_q[$];
  logic dat_q[$];
  int   n_viol    = 0;
  int   n_miso_hi = 0;

  always @(negedge scan_clk) begin
    if (scan_reset_ === 1'b1) begin
      for (int i = 0; i < 5; i++) begin
        if (enas[i]) begin
          ev_q.push_back(i);
          if (i == 2) dat_q.push_back(store_mask_shift_data);
          else if (i == 3) dat_q.push_back(trigger_mask_shift_data);
          else dat_q.push_back(cmd_shift_data);
        end
      end
      if (cmd_shift_update) ev_q.push_back(5);
      if (status_shift_update) ev_q.push_back(6);
      if (data_shift_update) ev_q.push_back(7);
      if ($countones(enas) > 1 ||
          (|enas && (cmd_shift_update || status_shift_update || data_shift_update)))
        n_viol <= n_viol + 1;
      if (spi_miso) n_miso_hi <= n_miso_hi + 1;
    end
  end

  // Frame model: what a frame with this address and payload length must produce.
  int exp_ev[$];

  task automatic model_frame(input logic [7:0] addr, input int nbits);
    int code;
    exp_ev.delete();
    code = (addr >= 8'd1 && addr <= 8'd5) ? int'(addr) - 1 : -1;
    if (addr == 8'h02) exp_ev.push_back(6);
    if (addr == 8'h05) exp_ev.push_back(7);
    if (code >= 0) for (int i = 0; i < nbits; i++) exp_ev.push_back(code);
    if (addr == 8'h01 && nbits > 0) exp_ev.push_back(5);
  endtask

  function automatic bit ev_match(input int start);
    if (ev_q.size() - start != exp_ev.size()) return 1'b0;
    for (int i = 0; i < exp_ev.size(); i++) if (ev_q[start + i] != exp_ev[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit dat_match(input int start, input logic [63:0] payload, input int n);
    if (dat_q.size() - start != n) return 1'b0;
    for (int i = 0; i < n; i++) if (dat_q[start + i] !== payload[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge scan_clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(HALF);
    m = spi_miso;  // master samples MISO on its rising edge
    spi_sclk = 1'b1;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] addr, input int nbits, input logic [63:0] payload,
                           output logic [63:0] mb, output logic oe);
    logic m;
    mb = '0;
    spi_cs_ = 1'b0;
    wait_clk(HALF);
    oe = spi_miso_oe;
    for (int i = 0; i < 8; i++) spi_bit(addr[i], m);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(payload[i], m);
      mb[i] = m;
    end
    wait_clk(HALF);
    spi_cs_ = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset;
    scan_reset_ = 1'b1;
    wait_clk(2);
    scan_reset_ = 1'b0;
    wait_clk(3);
    checks++;
    if (all_outs !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected %b", all_outs, 13'h0);
    end
    scan_reset_ = 1'b1;
    wait_clk(4);
    checks++;
    if (all_outs !== 13'h0) begin
      errors++;
      $display("FAIL idle_outputs: got %b, expected %b", all_outs, 13'h0);
    end
  endtask

  task automatic test_cmd_frame;
    int s = ev_q.size();
    int d = dat_q.size();
    logic [63:0] mb;
    logic oe;
    spi_frame(8'h01, 3, 64'b101, mb, oe);
    model_frame(8'h01, 3);
    checks++;
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL cmd_miso_oe: got %b, expected 1", oe);
    end
    checks++;
    if (ev_match(s) !== 1'b1) begin
      errors++;
      $display("FAIL cmd_events: got %0d events, expected %0d", ev_q.size() - s, exp_ev.size());
    end
    checks++;
    if (dat_match(d, 64'b101, 3) !== 1'b1) begin
      errors++;
      $display("FAIL cmd_data: got %0d bits, expected bits 1,0,1", dat_q.size() - d);
    end
  endtask

  task automatic test_status_frame;
    int s = ev_q.size();
    int d = dat_q.size();
    logic [63:0] pl = {$urandom, $urandom};
    logic [63:0] mb;
    logic oe;
    spi_frame(8'h02, 64, pl, mb, oe);
    model_frame(8'h02, 64);
    checks++;
    if (ev_match(s) !== 1'b1) begin
      errors++;
      $display("FAIL status_events: got %0d events, expected %0d", ev_q.size() - s,
               exp_ev.size());
    end
    checks++;
    if (dat_match(d, pl, 64) !== 1'b1) begin
      errors++;
      $display("FAIL status_data: got %0d bits, expected %0d", dat_q.size() - d, 64);
    end
    checks++;
    if (mb !== {8{8'hA5}}) begin
      errors++;
      $display("FAIL status_miso: got %h, expected %h", mb, {8{8'hA5}});
    end
  endtask

  task automatic test_store_mask;
    int s = ev_q.size();
    int d = dat_q.size();
    logic [63:0] pl = 64'h0000_1234_5678_9ABC;
    logic [63:0] mb;
    logic oe;
    spi_frame(8'h03, 48, pl, mb, oe);
    model_frame(8'h03, 48);
    checks++;
    if (ev_match(s) !== 1'b1) begin
      errors++;
      $display("FAIL store_events: got %0d events, expected %0d", ev_q.size() - s,
               exp_ev.size());
    end
    checks++;
    if (dat_match(d, pl, 48) !== 1'b1) begin
      errors++;
      $display("FAIL store_data: got %0d bits, expected %0d", dat_q.size() - d, 48);
    end
  endtask

  task automatic test_none;
    int s = ev_q.size();
    int h = n_miso_hi;
    logic [63:0] mb;
    logic oe;
    spi_frame(8'h7F, 16, {$urandom, $urandom}, mb, oe);
    checks++;
    if (ev_q.size() - s !== 0) begin
      errors++;
      $display("FAIL none_events: got %0d events, expected 0", ev_q.size() - s);
    end
    checks++;
    if (n_miso_hi - h !== 0) begin
      errors++;
      $display("FAIL none_miso: got %0d cycles of MISO high, expected 0", n_miso_hi - h);
    end
  endtask

  task automatic test_cmd_zero_bits;
    int s = ev_q.size();
    logic [63:0] mb;
    logic oe;
    spi_frame(8'h01, 0, '0, mb, oe);
    checks++;
    if (ev_q.size() - s !== 0) begin
      errors++;
      $display("FAIL cmd_zero_events: got %0d events, expected 0", ev_q.size() - s);
    end
  endtask

  task automatic test_abort;
    int s = ev_q.size();
    int d;
    logic m;
    logic [7:0] part = 8'h02;
    logic [63:0] pl = {32'h0, $urandom};
    logic [63:0] mb;
    logic oe;
    spi_cs_ = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) spi_bit(part[i], m);
    wait_clk(HALF);
    spi_cs_ = 1'b1;
    wait_clk(8);
    checks++;
    if (ev_q.size() - s !== 0) begin
      errors++;
      $display("FAIL abort_events: got %0d events, expected 0", ev_q.size() - s);
    end
    s = ev_q.size();
    d = dat_q.size();
    spi_frame(8'h04, 8, pl, mb, oe);
    model_frame(8'h04, 8);
    checks++;
    if (ev_match(s) !== 1'b1) begin
      errors++;
      $display("FAIL trig_events: got %0d events, expected %0d", ev_q.size() - s,
               exp_ev.size());
    end
    checks++;
    if (dat_match(d, pl, 8) !== 1'b1) begin
      errors++;
      $display("FAIL trig_data: got %0d bits, expected %0d", dat_q.size() - d, 8);
    end
  endtask

  task automatic test_reset_mid_frame;
    int s;
    logic m;
    logic [7:0] a = 8'h05;
    logic oe_before;
    logic [63:0] pl = {32'h0, $urandom};
    logic [63:0] mb;
    logic oe;
    data_load = $urandom;
    spi_cs_ = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) spi_bit(a[i], m);
    for (int i = 0; i < 4; i++) spi_bit(pl[i], m);
    oe_before = spi_miso_oe;
    scan_reset_ = 1'b0;
    #1;
    checks++;
    if (oe_before !== 1'b1 || all_outs !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_frame: oe before %b, outputs %b, expected 1 and %b",
               oe_before, all_outs, 13'h0);
    end
    spi_cs_ = 1'b1;
    wait_clk(3);
    scan_reset_ = 1'b1;
    wait_clk(5);
    s = ev_q.size();
    spi_frame(8'h05, 8, pl, mb, oe);
    model_frame(8'h05, 8);
    checks++;
    if (ev_match(s) !== 1'b1) begin
      errors++;
      $display("FAIL data_events: got %0d events, expected %0d", ev_q.size() - s,
               exp_ev.size());
    end
    checks++;
    if (mb[7:0] !== data_load[7:0]) begin
      errors++;
      $display("FAIL data_miso: got %h, expected %h", mb[7:0], data_load[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 8; f++) begin
      int s = ev_q.size();
      int d = dat_q.size();
      logic [7:0] a;
      int n;
      logic [63:0] pl = {$urandom, $urandom};
      logic [63:0] mb;
      logic oe;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      n = $urandom_range(0, 24);
      spi_frame(a, n, pl, mb, oe);
      model_frame(a, n);
      checks++;
      if (ev_match(s) !== 1'b1) begin
        errors++;
        $display("FAIL b2b_events addr=%h bits=%0d: got %0d events, expected %0d", a, n,
                 ev_q.size() - s, exp_ev.size());
      end
      checks++;
      if (dat_match(d, pl, (a >= 8'd1 && a <= 8'd5) ? n : 0) !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data addr=%h bits=%0d: got %0d bits", a, n, dat_q.size() - d);
      end
    end
  endtask

  task automatic test_exclusive_strobes;
    checks++;
    if (n_viol !== 0) begin
      errors++;
      $display("FAIL exclusive_strobes: got %0d overlapping cycles, expected 0", n_viol);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_frame();
    test_status_frame();
    test_store_mask();
    test_none();
    test_cmd_zero_bits();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_exclusive_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
